al422_frame_writer: RTL and testbench

- Write side of the AL422 frame buffer; the counterpart of the LED read/BAM engine.
- Accepts a byte stream with start-of-frame marking over a valid/ready handshake.
- Resets the AL422 write pointer at each frame start, then writes exactly FRAME_BYTES bytes sequentially, so the reader sees byte 0 of the frame at read address 0.
- Sits between the host interface (SPI/parallel bridge) and the AL422 write port. AL422 WCK is driven by in_clk on the board.

---
 rtl/al422_frame_writer.sv | 146 ++++++++++++++
 tb/tb_al422_frame_writer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/al422_frame_writer.sv
// Write side of the AL422 frame buffer: turns an SOF-marked byte stream into
// one /WRST pulse followed by exactly FRAME_BYTES sequential writes.
module al422_frame_writer #(
  parameter int FRAME_BYTES = 8192,
  parameter int WRST_CYCLES = 2
) (
  input  logic       in_clk,
  input  logic       in_nrst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [7:0] al422_data_out,
  output logic       al422_we_out,
  output logic       al422_wrst_out,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       byte_drop,
  output logic [7:0] frame_cnt,
  output logic [1:0] dbg_state_o
);

  // Handshake: a byte transfers on a rising in_clk when in_valid && in_ready;
  // in_data/in_sof must hold while in_valid is high and in_ready is low.

  localparam int CW  = $clog2(FRAME_BYTES);
  localparam int WCW = (WRST_CYCLES > 1) ? $clog2(WRST_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST_BYTE = CW'(FRAME_BYTES - 1);
  localparam logic [WCW-1:0] LAST_WRST = WCW'(WRST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRST   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [7:0]     data_q, data_d;
  logic           we_q, we_d;
  logic           wrst_q, wrst_d;
  logic           done_q, done_d;
  logic           abort_q, abort_d;
  logic           drop_q, drop_d;
  logic [7:0]     fcnt_q, fcnt_d;
  logic           ready_c;

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      data_q  <= 8'h00;
      we_q    <= 1'b1;
      wrst_q  <= 1'b1;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      drop_q  <= 1'b0;
      fcnt_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      we_q    <= we_d;
      wrst_q  <= wrst_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      drop_q  <= drop_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    we_d    = 1'b1;
    wrst_d  = 1'b1;
    done_d  = 1'b0;
    abort_d = 1'b0;
    drop_d  = 1'b0;
    fcnt_d  = fcnt_q;
    ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = in_valid && !in_sof;
        if (in_valid && !in_sof) begin
          drop_d = 1'b1;
        end else if (in_valid && in_sof) begin
          // SOF byte stays on the bus; it is taken as byte 0 after /WRST.
          state_d = S_WRST;
          wrst_d  = 1'b0;
          wcnt_d  = '0;
        end
      end
      S_WRST: begin
        cnt_d = '0;
        if (wcnt_q == LAST_WRST) begin
          state_d = S_STREAM;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
          wrst_d = 1'b0;
        end
      end
      S_STREAM: begin
        ready_c = !(in_sof && (cnt_q != '0));
        if (in_valid && ready_c) begin
          data_d = in_data;
          we_d   = 1'b0;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_BYTE) state_d = S_DONE;
        end else if (in_valid && in_sof) begin
          abort_d = 1'b1;
          state_d = S_WRST;
          wrst_d  = 1'b0;
          wcnt_d  = '0;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        fcnt_d  = fcnt_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is combinational, so it is gated by reset directly.
  assign in_ready       = in_nrst && ready_c;
  assign al422_data_out = data_q;
  assign al422_we_out   = we_q;
  assign al422_wrst_out = wrst_q;
  assign frame_done     = done_q;
  assign frame_abort    = abort_q;
  assign byte_drop      = drop_q;
  assign frame_cnt      = fcnt_q;
  assign dbg_state_o    = state_q;

  a_no_we_wrst_overlap: assert property (@(posedge in_clk) disable iff (!in_nrst)
    !(!al422_we_out && !al422_wrst_out));

endmodule

// File: tb/tb_al422_frame_writer.sv
// Randomized bench for al422_frame_writer: a frame-level reference model feeds
// an expected-event queue that a negedge monitor drains against the DUT pins.
module tb_al422_frame_writer;

  localparam int FB  = 8192;
  localparam int WC  = 2;
  localparam int FB2 = 4;
  localparam int WC2 = 1;

  localparam logic [3:0] EV_WR    = 4'd0;
  localparam logic [3:0] EV_WRST  = 4'd1;
  localparam logic [3:0] EV_DROP  = 4'd2;
  localparam logic [3:0] EV_ABORT = 4'd3;
  localparam logic [3:0] EV_DONE  = 4'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0, in_sof = 1'b0;
  logic       in_ready, we, wrst, done, abort, drop;
  logic [7:0] wd, fcnt;
  logic [1:0] dbg;

  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0, s_sof = 1'b0;
  logic       s_ready, s_we, s_wrst, s_done, s_abort, s_drop;
  logic [7:0] s_wd, s_fcnt;
  logic [1:0] s_dbg;

  al422_frame_writer #(.FRAME_BYTES(FB), .WRST_CYCLES(WC)) dut (
    .in_clk(clk), .in_nrst(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .al422_data_out(wd), .al422_we_out(we),
    .al422_wrst_out(wrst), .frame_done(done), .frame_abort(abort),
    .byte_drop(drop), .frame_cnt(fcnt), .dbg_state_o(dbg));

  al422_frame_writer #(.FRAME_BYTES(FB2), .WRST_CYCLES(WC2)) dut_s (
    .in_clk(clk), .in_nrst(rst_n), .in_data(s_data), .in_valid(s_valid),
    .in_sof(s_sof), .in_ready(s_ready), .al422_data_out(s_wd), .al422_we_out(s_we),
    .al422_wrst_out(s_wrst), .frame_done(s_done), .frame_abort(s_abort),
    .byte_drop(s_drop), .frame_cnt(s_fcnt), .dbg_state_o(s_dbg));

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  exp2_q[$];

  // reference model state (frame level)
  bit         m_in_frame = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_fc = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic model_byte(input logic [7:0] d, input logic s);
    if (!m_in_frame) begin
      if (!s) begin
        exp_q.push_back({EV_DROP, 8'h00});
        return;
      end
      exp_q.push_back({EV_WRST, 8'h00});
      m_in_frame = 1'b1;
      m_cnt = 0;
    end else if (s && m_cnt != 0) begin
      exp_q.push_back({EV_ABORT, 8'h00});
      exp_q.push_back({EV_WRST, 8'h00});
      m_cnt = 0;
    end
    exp_q.push_back({EV_WR, d});
    m_cnt++;
    if (m_cnt == FB) begin
      m_fc = m_fc + 8'd1;
      exp_q.push_back({EV_DONE, m_fc});
      m_in_frame = 1'b0;
      m_cnt = 0;
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    in_valid = 1'b0;
    s_valid  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    bit ok;
    int n;
    model_byte(d, s);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 64) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) fail_now("handshake_timeout");
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d, input logic s);
    bit ok;
    int n;
    exp2_q.push_back(d);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = s;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 64) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) fail_now("small_handshake_timeout");
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] first, input bit counting, input bit gaps);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (i == 0) d = first;
      else if (counting) d = i[7:0];
      else d = 8'($urandom);
      send(d, i == 0);
      if (gaps) idle(1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    idle(3);
  endtask

  task automatic drain2();
    int n;
    n = 0;
    while (exp2_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp2_q.size() != 0) fail_now("small_drain_timeout");
    idle(4);
  endtask

  // scoreboard monitor
  task automatic pop_ev(input logic [3:0] t, input logic [7:0] d, input string name);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event, data %0h, queue empty at %0t", name, d, $time);
    end else begin
      e = exp_q.pop_front();
      chk(name, int'({t, d}), int'(e));
    end
  endtask

  logic prev_wrst = 1'b1;
  int   wrst_run = 0, we_run = 0, last_we_run = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (abort) pop_ev(EV_ABORT, 8'h00, "abort");
      if (!wrst && prev_wrst) pop_ev(EV_WRST, 8'h00, "wrst_start");
      if (!we) pop_ev(EV_WR, wd, "write");
      if (drop) pop_ev(EV_DROP, 8'h00, "drop");
      if (done) pop_ev(EV_DONE, fcnt, "done_frame_cnt");
      if (!we || !wrst) chk("we_wrst_overlap", int'(!we && !wrst), 0);
      if (!wrst) wrst_run++;
      else if (wrst_run != 0) begin
        chk("wrst_len", wrst_run, WC);
        wrst_run = 0;
      end
      if (!we) we_run++;
      else if (we_run != 0) begin
        last_we_run = we_run;
        we_run = 0;
      end
      prev_wrst = wrst;
    end else begin
      prev_wrst = 1'b1;
      wrst_run  = 0;
      we_run    = 0;
    end
  end

  int we2_cycles = 0, wrst2_cycles = 0, done2_cnt = 0;
  logic [7:0] e2;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!s_we) begin
        we2_cycles++;
        if (exp2_q.size() == 0) fail_now("small_unexpected_write");
        else begin
          e2 = exp2_q.pop_front();
          chk("small_write", int'(s_wd), int'(e2));
        end
      end
      if (!s_wrst) wrst2_cycles++;
      if (s_done) done2_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with a non-SOF byte offered to prove in_ready stays low
    #1 rst_n = 1'b0;
    in_valid = 1'b1;
    in_sof = 1'b0;
    #1;
    chk("rst_we", int'(we), 1);
    chk("rst_wrst", int'(wrst), 1);
    chk("rst_data", int'(wd), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_pulses", int'({done, abort, drop}), 0);
    chk("rst_frame_cnt", int'(fcnt), 0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // full-rate counting frame
    send_frame(FB, 8'h00, 1'b1, 1'b0);
    drain();
    chk("t1_we_run", last_we_run, FB);
    chk("t1_frame_cnt", int'(fcnt), 1);

    // in_valid toggling
    send_frame(FB, 8'h00, 1'b1, 1'b1);
    drain();
    chk("t2_we_run", last_we_run, 1);
    chk("t2_frame_cnt", int'(fcnt), 2);

    // bytes in IDLE are dropped, SOF 0x02 becomes byte 0
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send_frame(FB, 8'h02, 1'b0, 1'b0);
    drain();
    chk("t3_frame_cnt", int'(fcnt), 3);

    // abort after 100 bytes, then a full frame
    send_frame(100, 8'($urandom), 1'b0, 1'b0);
    drain();
    chk("t4_frame_cnt_held", int'(fcnt), 3);
    send_frame(FB, 8'($urandom), 1'b0, 1'b0);
    drain();
    chk("t4_frame_cnt", int'(fcnt), 4);

    // asynchronous reset at cnt=500
    send_frame(500, 8'($urandom), 1'b0, 1'b0);
    drain();
    in_valid = 1'b1;
    in_sof = 1'b0;
    in_data = 8'($urandom);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_we", int'(we), 1);
    chk("t5_wrst", int'(wrst), 1);
    chk("t5_data", int'(wd), 0);
    chk("t5_ready", int'(in_ready), 0);
    chk("t5_frame_cnt", int'(fcnt), 0);
    exp_q.delete();
    m_in_frame = 1'b0;
    m_cnt = 0;
    m_fc = 8'h00;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    drain();

    // small instance: 256 frames, frame_cnt wraps
    for (int f = 0; f < 255; f++)
      for (int b = 0; b < FB2; b++) send2(8'($urandom), b == 0);
    drain2();
    chk("small_frame_cnt_255", int'(s_fcnt), 255);
    for (int b = 0; b < FB2; b++) send2(8'($urandom), b == 0);
    drain2();
    chk("small_frame_cnt_wrap", int'(s_fcnt), 0);
    chk("small_done_cnt", done2_cnt, 256);
    chk("small_wrst_cycles", wrst2_cycles, 256 * WC2);
    chk("small_we_cycles", we2_cycles, 256 * FB2);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
